// File: rtl/rv_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : rv_lsu
//  Purpose  : Load/store unit: word-aligned data bus with byte enables,
//             sign/zero-extended load return, one access outstanding.
//             Define MISALIGN_SPLIT_EN to split misaligned accesses into
//             two bus beats instead of rejecting them.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_lsu #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        mem_op,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

`ifdef MISALIGN_SPLIT_EN
    localparam logic c_split_en = 1'b1;
`else
    localparam logic c_split_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [XLEN-1:0]     r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [3:0]          r_bus_be;
    logic [XLEN-1:0]     r_bus_wdata;
    logic [2:0]          r_op;
    logic                r_we;
    logic [1:0]          r_off;
    logic                r_split;
    logic [3:0]          r_be1;
    logic [XLEN-1:0]     r_rdata0;

    logic [3:0]          w_mask;
    logic                w_invalid;
    logic [1:0]          w_off;
    logic                w_misalign;
    logic [7:0]          w_be8;
    logic [2*XLEN-1:0]   w_wrot64;
    logic                w_reject;
    logic                w_split;

    // Decode the access size; stores cannot use the unsigned load encodings.
    always_comb begin
        w_mask    = 4'b0000;
        w_invalid = 1'b0;
        case (mem_op)
            3'b001, 3'b101: w_mask = 4'b0001;
            3'b010, 3'b110: w_mask = 4'b0011;
            3'b011:         w_mask = 4'b1111;
            default:        w_invalid = 1'b1;
        endcase
        if (mem_write && mem_op[2])
            w_invalid = 1'b1;
    end

    assign w_off      = addr[1:0];
    assign w_misalign = ((mem_op[1:0] == 2'b10) && (w_off == 2'b11)) ||
                        ((mem_op[1:0] == 2'b11) && (w_off != 2'b00));
    assign w_be8      = {4'b0000, w_mask} << w_off;
    // Upper half of the doubled word shifted left is the rotate-left result.
    assign w_wrot64   = {wdata, wdata} << {w_off, 3'b000};
    assign w_reject   = w_invalid | (w_misalign & ~c_split_en);
    assign w_split    = w_misalign & c_split_en;

    function automatic logic [XLEN-1:0] f_extract(input logic [2*XLEN-1:0] d,
                                                  input logic [1:0]        off,
                                                  input logic [2:0]        op);
        logic [XLEN-1:0] s;
        s = XLEN'(d >> {off, 3'b000});
        case (op)
            3'b001:  f_extract = {{(XLEN-8){s[7]}}, s[7:0]};
            3'b101:  f_extract = {{(XLEN-8){1'b0}}, s[7:0]};
            3'b010:  f_extract = {{(XLEN-16){s[15]}}, s[15:0]};
            3'b110:  f_extract = {{(XLEN-16){1'b0}}, s[15:0]};
            default: f_extract = s;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= '0;
            r_op        <= 3'b000;
            r_we        <= 1'b0;
            r_off       <= 2'b00;
            r_split     <= 1'b0;
            r_be1       <= 4'b0000;
            r_rdata0    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_op        <= mem_op;
                        r_we        <= mem_write;
                        r_off       <= w_off;
                        r_split     <= w_split;
                        r_be1       <= w_be8[7:4];
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        if (w_reject) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state     <= REQ0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_bus_be    <= w_be8[3:0];
                            r_bus_wdata <= w_wrot64[2*XLEN-1:XLEN];
                        end
                    end
                end
                REQ0: begin
                    if (bus_gnt) begin
                        if (r_we && r_split) begin
                            r_state    <= REQ1;
                            r_bus_addr <= r_bus_addr + ADDR_W'(4);
                            r_bus_be   <= r_be1;
                        end else if (r_we) begin
                            r_state     <= RESP;
                            r_bus_req   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state   <= WAIT0;
                            r_bus_req <= 1'b0;
                        end
                    end
                end
                WAIT0: begin
                    if (bus_rvalid) begin
                        r_rdata0 <= bus_rdata;
                        if (r_split) begin
                            r_state    <= REQ1;
                            r_bus_req  <= 1'b1;
                            r_bus_addr <= r_bus_addr + ADDR_W'(4);
                            r_bus_be   <= r_be1;
                        end else begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= f_extract({{XLEN{1'b0}}, bus_rdata}, r_off, r_op);
                        end
                    end
                end
                REQ1: begin
                    if (bus_gnt) begin
                        r_bus_req <= 1'b0;
                        if (r_we) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (bus_rvalid) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= f_extract({bus_rdata, r_rdata0}, r_off, r_op);
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_bus_req   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rv_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_lsu
//  Purpose  : Directed self-checking bench for rv_lsu; split-beat cases are
//             selected by MISALIGN_SPLIT_EN, matching the design build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  mem_op;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_vec = 0;
    int n_err = 0;

    rv_lsu #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_op(mem_op), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns in the cycle after accept.
    task automatic issue(input logic [2:0] op, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        mem_op = op; mem_write = we; addr = a; wdata = d; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
        n_vec++; if (bus_we !== 1'b0) begin n_err++; $display("FAIL reset_bus_we got %b exp 0", bus_we); end
        n_vec++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr); end
        n_vec++; if (bus_be !== 4'b0) begin n_err++; $display("FAIL reset_bus_be got %b exp 0000", bus_be); end
        n_vec++; if (bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset_bus_wdata got %h exp 0", bus_wdata); end
    endtask

    task automatic test_store_byte();
        issue(3'b001, 1'b1, 32'h0000_1002, 32'h0000_00A5);
        n_vec++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL sb_req got %b exp 1", bus_req); end
        n_vec++; if (bus_we !== 1'b1) begin n_err++; $display("FAIL sb_we got %b exp 1", bus_we); end
        n_vec++; if (bus_addr !== 32'h0000_1000) begin n_err++; $display("FAIL sb_addr got %h exp 00001000", bus_addr); end
        n_vec++; if (bus_be !== 4'b0100) begin n_err++; $display("FAIL sb_be got %b exp 0100", bus_be); end
        n_vec++; if (bus_wdata !== 32'h00A5_0000) begin n_err++; $display("FAIL sb_wdata got %h exp 00a50000", bus_wdata); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL sb_busy_ready got %b exp 0", req_ready); end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sb_rsp_valid_t2 got %b exp 1", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL sb_rsp_err got %b exp 0", rsp_err); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL sb_rsp_rdata got %h exp 0", rsp_rdata); end
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL sb_req_drop got %b exp 0", bus_req); end
        tick();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL sb_rsp_pulse got %b exp 0", rsp_valid); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready_back got %b exp 1", req_ready); end
    endtask

    task automatic test_load_byte();
        logic [2:0]  op;
        logic [31:0] exp_d;
        for (int i = 0; i < 2; i++) begin
            op    = (i == 0) ? 3'b001 : 3'b101;
            exp_d = (i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            issue(op, 1'b0, 32'h0000_2001, 32'h0);
            n_vec++; if (bus_be !== 4'b0010) begin n_err++; $display("FAIL lb_be[%0d] got %b exp 0010", i, bus_be); end
            n_vec++; if (bus_we !== 1'b0) begin n_err++; $display("FAIL lb_we[%0d] got %b exp 0", i, bus_we); end
            n_vec++; if (bus_addr !== 32'h0000_2000) begin n_err++; $display("FAIL lb_addr[%0d] got %h exp 00002000", i, bus_addr); end
            bus_gnt = 1'b1;
            tick();
            bus_gnt = 1'b0;
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lb_early_rsp[%0d] got %b exp 0", i, rsp_valid); end
            bus_rvalid = 1'b1; bus_rdata = 32'h0000_8000;
            tick();
            bus_rvalid = 1'b0; bus_rdata = 32'h0;
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL lb_rsp_valid_t3[%0d] got %b exp 1", i, rsp_valid); end
            n_vec++; if (rsp_rdata !== exp_d) begin n_err++; $display("FAIL lb_rdata[%0d] got %h exp %h", i, rsp_rdata, exp_d); end
            n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL lb_err[%0d] got %b exp 0", i, rsp_err); end
            tick();
        end
    endtask

    task automatic test_load_half_stall();
        logic [2:0]  op;
        logic [31:0] exp_d;
        for (int i = 0; i < 2; i++) begin
            op    = (i == 0) ? 3'b010 : 3'b110;
            exp_d = (i == 0) ? 32'hFFFF_8001 : 32'h0000_8001;
            issue(op, 1'b0, 32'h0000_3002, 32'h0);
            // Lower half of the 3-cycle grant stall on the signed access only.
            if (i == 0) begin
                for (int s = 0; s < 3; s++) begin
                    n_vec++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_3000 || bus_be !== 4'b1100 || bus_we !== 1'b0)
                        begin n_err++; $display("FAIL lh_stall_hold[%0d] got req=%b addr=%h be=%b we=%b exp 1/00003000/1100/0", s, bus_req, bus_addr, bus_be, bus_we); end
                    tick();
                end
            end
            n_vec++; if (bus_req !== 1'b1 || bus_be !== 4'b1100) begin n_err++; $display("FAIL lh_req[%0d] got req=%b be=%b exp 1/1100", i, bus_req, bus_be); end
            bus_gnt = 1'b1;
            tick();
            bus_gnt = 1'b0;
            bus_rvalid = 1'b1; bus_rdata = 32'h8001_1234;
            tick();
            bus_rvalid = 1'b0; bus_rdata = 32'h0;
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL lh_rsp_valid[%0d] got %b exp 1", i, rsp_valid); end
            n_vec++; if (rsp_rdata !== exp_d) begin n_err++; $display("FAIL lh_rdata[%0d] got %h exp %h", i, rsp_rdata, exp_d); end
            tick();
        end
    endtask

    task automatic test_word_aligned();
        issue(3'b011, 1'b1, 32'h0000_6000, 32'h1234_5678);
        n_vec++; if (bus_be !== 4'b1111 || bus_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL sw_beat got be=%b wdata=%h exp 1111/12345678", bus_be, bus_wdata); end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL sw_rsp got %b exp 1", rsp_valid); end
        tick();
        issue(3'b011, 1'b0, 32'h0000_6004, 32'h0);
        n_vec++; if (bus_addr !== 32'h0000_6004 || bus_be !== 4'b1111) begin n_err++; $display("FAIL lw_beat got addr=%h be=%b exp 00006004/1111", bus_addr, bus_be); end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL lw_rsp got v=%b d=%h exp 1/cafef00d", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_misaligned_word();
        issue(3'b011, 1'b0, 32'h0000_4001, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        n_vec++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_4000 || bus_be !== 4'b1110) begin n_err++; $display("FAIL lw_split_b0 got req=%b addr=%h be=%b exp 1/00004000/1110", bus_req, bus_addr, bus_be); end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h3322_11AA;
        tick();
        bus_rvalid = 1'b0;
        n_vec++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_4004 || bus_be !== 4'b0001) begin n_err++; $display("FAIL lw_split_b1 got req=%b addr=%h be=%b exp 1/00004004/0001", bus_req, bus_addr, bus_be); end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lw_split_early got %b exp 0", rsp_valid); end
        bus_rvalid = 1'b1; bus_rdata = 32'hBBCC_DD44;
        tick();
        bus_rvalid = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h4433_2211) begin n_err++; $display("FAIL lw_split_rsp got v=%b e=%b d=%h exp 1/0/44332211", rsp_valid, rsp_err, rsp_rdata); end
`else
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL lw_misalign_rsp got v=%b e=%b d=%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL lw_misalign_noreq got %b exp 0", bus_req); end
`endif
        tick();
    endtask

    task automatic test_invalid_ops();
        logic [2:0] op;
        logic       we;
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? 3'b111 : 3'b101;
            we = (i == 0) ? 1'b0 : 1'b1;
            issue(op, we, 32'h0000_7000, 32'hFFFF_FFFF);
            n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_err++; $display("FAIL invalid_rsp[%0d] got v=%b e=%b exp 1/1", i, rsp_valid, rsp_err); end
            n_vec++; if (bus_req !== 1'b0 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL invalid_nobus[%0d] got req=%b d=%h exp 0/0", i, bus_req, rsp_rdata); end
            tick();
            n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL invalid_idle[%0d] got rdy=%b v=%b exp 1/0", i, req_ready, rsp_valid); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(3'b011, 1'b0, 32'h0000_5000, 32'h0);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b1 || bus_req !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid got rdy=%b req=%b v=%b exp 1/0/0", req_ready, bus_req, rsp_valid); end
        #2;
        rst = 1'b0;
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        tick();
        bus_rvalid = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_valid !== 1'b0) seen++;
            tick();
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rst_stray_rvalid got %0d rsp pulses exp 0", seen); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_wrap();
        issue(3'b011, 1'b1, 32'hFFFF_FFFE, 32'h1122_3344);
`ifdef MISALIGN_SPLIT_EN
        n_vec++; if (bus_addr !== 32'hFFFF_FFFC || bus_be !== 4'b1100 || bus_wdata !== 32'h3344_1122) begin n_err++; $display("FAIL wrap_b0 got addr=%h be=%b wd=%h exp fffffffc/1100/33441122", bus_addr, bus_be, bus_wdata); end
        bus_gnt = 1'b1;
        tick();
        n_vec++; if (bus_req !== 1'b1 || bus_addr !== 32'h0 || bus_be !== 4'b0011 || bus_wdata !== 32'h3344_1122) begin n_err++; $display("FAIL wrap_b1 got req=%b addr=%h be=%b wd=%h exp 1/00000000/0011/33441122", bus_req, bus_addr, bus_be, bus_wdata); end
        tick();
        bus_gnt = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL wrap_rsp got v=%b e=%b exp 1/0", rsp_valid, rsp_err); end
`else
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || bus_req !== 1'b0) begin n_err++; $display("FAIL wrap_reject got v=%b e=%b req=%b exp 1/1/0", rsp_valid, rsp_err, bus_req); end
`endif
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_op = 3'b000; mem_write = 1'b0;
        addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_store_byte();
        test_load_byte();
        test_load_half_stall();
        test_word_aligned();
        test_misaligned_word();
        test_invalid_ops();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
Load/store unit that executes the memory half of decoded instructions. It consumes mem_op, mem_write and the ALU-computed address from the execute stage, then drives a word-aligned data-memory bus with byte enables. It returns sign- or zero-extended load data to writeback. It sits between the execute stage and data memory and holds one access outstanding at a time.

Parameters:
ADDR_W, 32, byte address width of addr and bus_addr
XLEN, 32, data width; fixed at 32, four byte lanes

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  execute stage presents an access
req_ready  output  1  LSU can accept; high only in IDLE
mem_op  input  3  001 b, 010 h, 011 w, 101 bu, 110 hu; others invalid
mem_write  input  1  1 = store, 0 = load
addr  input  ADDR_W  byte address (rs1+imm)
wdata  input  XLEN  store data (rs2)
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  XLEN  extended load data; 0 for stores and errors
rsp_err  output  1  qualified by rsp_valid; invalid op or misaligned
bus_req  output  1  bus request; held until bus_gnt
bus_we  output  1  write strobe
bus_addr  output  ADDR_W  word-aligned address, addr[1:0] = 0
bus_be  output  4  byte enables
bus_wdata  output  XLEN  lane-positioned store data
bus_gnt  input  1  request accepted in cycle where bus_req & bus_gnt
bus_rvalid  input  1  read data valid; at least 1 cycle after gnt
bus_rdata  input  XLEN  read data

Behaviour:
- Reset (async): state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; bus_req=0; bus_we=0; bus_addr=0; bus_be=0; bus_wdata=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Accept: req_valid&req_ready in IDLE latches mem_op, mem_write, addr, wdata, and off=addr[1:0].
- Size mask m: byte 0001, half 0011, word 1111.
- Store with mem_op 101/110, or mem_op in {000,100,111}, is invalid: go to RESP with err=1, no bus traffic.
- Misaligned access: half with off=3, or word with off!=0.
- Byte and aligned access: single beat.
  - bus_addr = {addr[ADDR_W-1:2],2'b00}.
  - bus_be = (m<<off)[3:0].
  - bus_wdata = wdata rotated left by 8*off.
- IDLE->REQ0: bus_req=1 from the cycle after accept.
- REQ0: hold bus_req and all bus outputs stable until bus_gnt.
  - Store: gnt ends the beat (no rvalid).
  - Load: go to WAIT0 and wait for bus_rvalid; capture rdata0.
- Last beat done -> RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Load result: shift {rdata1,rdata0} right by 8*off, keep the low 8/16/32 bits.
  - 001/010: sign-extend.
  - 101/110: zero-extend.
- Latency, zero bus wait states:
  - Store: accept T0, req+gnt T1, rsp_valid T2.
  - Load: accept T0, gnt T1, rvalid T2, rsp_valid T3.
- bus_rvalid outside WAIT0/WAIT1 is ignored.
- Reset mid-access: immediate return to IDLE with bus_req=0 and no rsp_valid; the transaction is dropped.
- Second-beat address wraps modulo 2^ADDR_W (0xFFFFFFFC+4 -> 0x00000000).

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: misaligned access splits into two beats.
  - Beat 0: word base, be=(m<<off)[3:0].
  - Beat 1: base+4, be=(m<<off)[7:4].
  - Both beats: bus_wdata = wdata rotated left by 8*off.
  - Beat 1 uses REQ1/WAIT1; load data is rdata1:rdata0. Latency grows by one beat; rsp_err=0.
- Undefined: misaligned access goes straight to RESP.
  - rsp_valid one cycle after accept, rsp_err=1, rsp_rdata=0, no bus_req.

Test Plan:
- sb, addr=0x1002, wdata=0x000000A5 -> bus_addr=0x1000, be=0100, bus_wdata byte2=0xA5, we=1; rsp_valid at T2, err=0.
- lb, addr=0x2001, bus_rdata=0x00008000 -> be=0010, rsp_rdata=0xFFFFFF80. lbu, same address and data -> 0x00000080.
- lh, addr=0x3002, rdata=0x8001xxxx -> 0xFFFF8001. lhu -> 0x00008001. Insert 3-cycle gnt stall -> bus outputs stable, rsp_valid delayed by 3.
- lw, addr=0x4001:
  - Split: beat0 0x4000 be=1110, beat1 0x4004 be=0001; rdata0=0x332211xx, rdata1=0xxxxxxx44 -> 0x44332211.
  - No split: rsp_err=1, no bus_req.
- mem_op=111 load, and store with mem_op=101 -> rsp_valid T1, rsp_err=1, no bus_req.
- rst asserted in WAIT0 with rvalid arriving later -> IDLE, req_ready=1, no rsp_valid, stray rvalid ignored. sw at 0xFFFFFFFE split -> beat1 bus_addr=0x00000000, be=0011.
